// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DROP,
    HOLD,
    HALTED
  } fetch_state_t;

  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [15:0] INSTR_NOP = 16'h0800;
  localparam logic [15:0] RESET_PC  = 16'h0000;

endpackage

// File: rtl/fetch_stage_out_reg.sv
// fetch_out_reg: load/clear output register holding the delivered instruction,
// its PC and PC+2. Clearing drops only the valid flag; the payload is kept.
module fetch_out_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clr,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_in,
  output logic        valid,
  output logic [15:0] instr,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2
);

  logic        valid_q, valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus2_d = pc_plus2_q;
    if (load) begin
      valid_d    = 1'b1;
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_plus2_d = pc_in + 16'd2;
    end else if (clr) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= INSTR_NOP;
      pc_q       <= '0;
      pc_plus2_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus2_q <= pc_plus2_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus2 = pc_plus2_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, memory request FSM, redirect/flush and HALT stop.
// Optional FETCH_STATS_EN adds saturating consumed/flushed instruction counters.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [4:0]  if_op,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic        halted
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] stat_fetch_cnt,
  output logic [15:0] stat_flush_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  fetch_addr_q, fetch_addr_d;
  logic [15:0]  redir_pc;
  logic         out_load, out_clr;
  logic         consume, flush;

  assign redir_pc = redirect_pc & 16'hFFFE;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    out_load     = 1'b0;
    out_clr      = 1'b0;
    consume      = 1'b0;
    flush        = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = redir_pc;
      end
      FETCH: begin
        fetch_addr_d = pc_q;
        if (redirect) begin
          pc_d    = redir_pc;
          flush   = 1'b1;
          state_d = imem_done ? FETCH : DROP;
        end else if (imem_done) begin
          out_load = 1'b1;
          pc_d     = pc_q + 16'd2;
          state_d  = HOLD;
        end
      end
      DROP: begin
        // A redirect only retargets the PC; the outstanding done still ends DROP.
        if (redirect) pc_d = redir_pc;
        if (imem_done) state_d = FETCH;
      end
      HOLD: begin
        if (redirect) begin
          out_clr = 1'b1;
          flush   = 1'b1;
          pc_d    = redir_pc;
          state_d = FETCH;
        end else if (id_ready) begin
          out_clr = 1'b1;
          consume = 1'b1;
          state_d = (if_op == OP_HALT) ? HALTED : FETCH;
        end
      end
      HALTED: begin
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  assign imem_req  = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr = (state_q == DROP) ? fetch_addr_q : pc_q;
  assign halted    = (state_q == HALTED);
  assign if_op     = if_instr[15:11];

  fetch_out_reg u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (out_load),
    .clr      (out_clr),
    .instr_in (imem_data),
    .pc_in    (pc_q),
    .valid    (if_valid),
    .instr    (if_instr),
    .pc       (if_pc),
    .pc_plus2 (if_pc_plus2)
  );

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (consume && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (flush && (flush_cnt_q != '1))   flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stat_fetch_cnt = fetch_cnt_q;
  assign stat_flush_cnt = flush_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = consume ^ flush;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a variable-latency memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        id_ready;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [4:0]  if_op;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetch_cnt;
  logic [15:0] stat_flush_cnt;
`endif

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_done   (imem_done),
    .imem_data   (imem_data),
    .id_ready    (id_ready),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_op       (if_op),
    .if_pc       (if_pc),
    .if_pc_plus2 (if_pc_plus2),
    .halted      (halted)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetch_cnt (stat_fetch_cnt),
    .stat_flush_cnt (stat_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory: done after 'lat' request cycles; word 0x0006 is HALT.
  int unsigned lat;
  int unsigned mcnt;
  assign imem_done = imem_req && (mcnt == lat);
  always_comb begin
    if (imem_addr == 16'h0006) imem_data = 16'h0000;
    else imem_data = 16'h4000 + {imem_addr[8:1], 8'h00};
  end
  always @(posedge clk or posedge rst) begin
    if (rst) mcnt <= 0;
    else if (imem_req) mcnt <= imem_done ? 0 : mcnt + 1;
  end

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pc_plus2;
  } exp_t;

  exp_t exp_q[$];
  int   cons_cyc[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cons   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] instr, input logic [15:0] pc2);
    exp_t e;
    e.pc = pc; e.instr = instr; e.pc_plus2 = pc2;
    exp_q.push_back(e);
  endtask

  // Monitor: every consumed instruction is popped and compared.
  always @(negedge clk) begin
    if (!rst && if_valid && id_ready && !redirect) begin
      n_cons++;
      cons_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_instr", {16'h0, if_pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", {16'h0, if_instr}, {16'h0, e.instr});
        chk("sb_pc", {16'h0, if_pc}, {16'h0, e.pc});
        chk("sb_pc_plus2", {16'h0, if_pc_plus2}, {16'h0, e.pc_plus2});
        chk("sb_op", {27'h0, if_op}, {27'h0, e.instr[15:11]});
      end
    end
  end

  task automatic wait_consumed(input int n);
    int target;
    target = n_cons + n;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (n_cons >= target) break;
    end
    chk("consume_timeout", (n_cons >= target) ? 32'd1 : 32'd0, 32'd1);
    #1 id_ready = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50; i++) begin
      if (if_valid) break;
      @(posedge clk); #1;
    end
    chk("valid_timeout", {31'h0, if_valid}, 32'd1);
  endtask

  task automatic do_redirect(input logic [15:0] a);
    redirect = 1'b1;
    redirect_pc = a;
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'h0, if_valid}, 32'd0);
    chk({tag, "_instr"}, {16'h0, if_instr}, 32'h0800);
    chk({tag, "_op"}, {27'h0, if_op}, 32'd1);
    chk({tag, "_pc"}, {16'h0, if_pc}, 32'd0);
    chk({tag, "_pc2"}, {16'h0, if_pc_plus2}, 32'd0);
    chk({tag, "_halted"}, {31'h0, halted}, 32'd0);
    chk({tag, "_req"}, {31'h0, imem_req}, 32'd0);
`ifdef FETCH_STATS_EN
    chk({tag, "_stat_fetch"}, {16'h0, stat_fetch_cnt}, 32'd0);
    chk({tag, "_stat_flush"}, {16'h0, stat_flush_cnt}, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0; lat = 0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");

    // Zero-wait stream 0x0000..0x0006, the last word being HALT.
    push(16'h0000, 16'h4000, 16'h0002);
    push(16'h0002, 16'h4100, 16'h0004);
    push(16'h0004, 16'h4200, 16'h0006);
    push(16'h0006, 16'h0000, 16'h0008);
    rst = 1'b0;
    chk("idle_no_req", {31'h0, imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("first_req", {31'h0, imem_req}, 32'd1);
    chk("first_addr", {16'h0, imem_addr}, 32'h0000);
    id_ready = 1'b1;
    wait_consumed(4);
    if (cons_cyc.size() >= 4) begin
      chk("throughput_a", cons_cyc[1] - cons_cyc[0], 32'd2);
      chk("throughput_b", cons_cyc[3] - cons_cyc[2], 32'd2);
    end else begin
      chk("throughput_cnt", cons_cyc.size(), 32'd4);
    end
    chk("halted_set", {31'h0, halted}, 32'd1);
    chk("halted_valid", {31'h0, if_valid}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("halted_no_req", {31'h0, imem_req}, 32'd0);
    end

    // Leave HALTED by redirect, then stall in HOLD for 5 cycles.
    push(16'h0020, 16'h5000, 16'h0022);
    do_redirect(16'h0020);
    chk("unhalt", {31'h0, halted}, 32'd0);
    chk("unhalt_req", {31'h0, imem_req}, 32'd1);
    chk("unhalt_addr", {16'h0, imem_addr}, 32'h0020);
    wait_valid();
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'h0, if_valid}, 32'd1);
      chk("stall_instr", {16'h0, if_instr}, 32'h5000);
      chk("stall_no_req", {31'h0, imem_req}, 32'd0);
    end
    id_ready = 1'b1;
    @(posedge clk); #1;
    id_ready = 1'b0;
    chk("resume_req", {31'h0, imem_req}, 32'd1);
    chk("resume_addr", {16'h0, imem_addr}, 32'h0022);
    @(posedge clk); #1;

    // 3-cycle memory; redirect during the wait forces DROP.
    lat = 3;
    do_redirect(16'h0040);
    chk("fetch40_addr", {16'h0, imem_addr}, 32'h0040);
    @(posedge clk); #1;
    do_redirect(16'h0101);
    chk("drop_req", {31'h0, imem_req}, 32'd1);
    chk("drop_addr", {16'h0, imem_addr}, 32'h0040);
    push(16'h0100, 16'hC000, 16'h0102);
    id_ready = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (imem_req && imem_addr == 16'h0100) begin seen = 1'b1; break; end
      end
      chk("refetch_0100", {31'h0, seen}, 32'd1);
    end
    wait_consumed(1);
    wait_valid();

    // Wrap from 0xFFFE to 0x0000.
    lat = 0;
    push(16'hFFFE, 16'h3F00, 16'h0000);
    push(16'h0000, 16'h4000, 16'h0002);
    do_redirect(16'hFFFE);
    id_ready = 1'b1;
    wait_consumed(2);
    wait_valid();
`ifdef FETCH_STATS_EN
    chk("stat_fetch", {16'h0, stat_fetch_cnt}, 32'd8);
    chk("stat_flush", {16'h0, stat_flush_cnt}, 32'd3);
`endif

    // Reset while a slow fetch is outstanding.
    lat = 5;
    do_redirect(16'h0200);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk_reset_outputs("midreset");
    @(posedge clk); #1;
    lat = 0;
    push(16'h0000, 16'h4000, 16'h0002);
    id_ready = 1'b1;
    rst = 1'b0;
    chk("restart_idle", {31'h0, imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("restart_req", {31'h0, imem_req}, 32'd1);
    chk("restart_addr", {16'h0, imem_addr}, 32'h0000);
    wait_consumed(1);
    wait_valid();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
